lfsr_period_checker: RTL and testbench

Self-checking monitor downstream of the 12-bit LFSR generator. It consumes the generator's state word and its once-per-sequence `max_tick` pulse on the same slow clock. On each `start` it measures the number of clock cycles between two consecutive `max_tick` pulses and reports pass/fail plus an error class: stuck state, early repeat of the sequence, or timeout. The result drives board LEDs and the verification bench.

---
 rtl/lfsr_pkg.sv | 29 ++
 rtl/lfsr_period_checker.sv | 149 ++++++++++++++
 tb/tb_lfsr_period_checker.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and types for the 12-bit LFSR generator and its period checker.
//   WIDTH       : LFSR state width
//   PERIOD      : expected maximal-length sequence period, 2^WIDTH - 1
//   CNT_W       : width of the cycle counter / reported period
//   CNT_MAX     : saturation value of the counter (timeout threshold)
//   state_e     : checker FSM states
//   ERR_*       : error class codes reported on the err output
package lfsr_pkg;

  localparam int unsigned WIDTH  = 12;
  localparam int unsigned PERIOD = (1 << WIDTH) - 1;
  localparam int unsigned CNT_W  = WIDTH + 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] PERIOD_CNT = CNT_W'(PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_STUCK   = 2'b01;
  localparam logic [1:0] ERR_REPEAT  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/lfsr_period_checker.sv
// Period checker for the 12-bit LFSR generator. On start it waits for a max_tick (ARM),
// then counts cycles until the next max_tick (MEASURE), flagging a stuck state, an early
// return to the seed value, or a counter timeout. Results are held until the next start.
//
// Ports:
//   i_clk       : clock shared with the LFSR (one LFSR step per cycle)
//   i_reset     : synchronous active-low reset
//   i_start     : measurement request, only honoured in IDLE
//   i_max_tick  : once-per-period pulse from the generator
//   i_lfsr_in   : current generator state
//   o_busy      : high while in ARM or MEASURE
//   o_done      : one-cycle pulse when a result is posted
//   o_pass      : measured period equals PERIOD with no error
//   o_err       : error class (ERR_NONE/STUCK/REPEAT/TIMEOUT)
//   o_period    : measured cycle count
module lfsr_period_checker
  import lfsr_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_max_tick,
  input  logic [WIDTH-1:0] i_lfsr_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [1:0]       o_err,
  output logic [CNT_W-1:0] o_period
);

  // ARM gives up on the edge that would take the counter to CNT_MAX.
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_MAX - CNT_W'(1);

  state_e           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [WIDTH-1:0] r_seed, w_seed;
  logic [WIDTH-1:0] r_prev, w_prev;
  logic             r_pass, w_pass;
  logic [1:0]       r_err, w_err;
  logic [CNT_W-1:0] r_period, w_period;
  logic             r_busy, w_busy;
  logic             r_done, w_done;

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_seed   = r_seed;
    w_prev   = r_prev;
    w_pass   = r_pass;
    w_err    = r_err;
    w_period = r_period;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_pass   = 1'b0;
          w_err    = ERR_NONE;
          w_period = '0;
          w_cnt    = '0;
          w_state  = ARM;
        end
      end

      ARM: begin
        if (i_max_tick) begin
          w_seed  = i_lfsr_in;
          w_prev  = i_lfsr_in;
          w_cnt   = CNT_W'(1);
          w_state = MEASURE;
        end else if (r_cnt == ARM_LAST) begin
          w_cnt    = CNT_MAX;
          w_err    = ERR_TIMEOUT;
          w_period = CNT_MAX;
          w_state  = DONE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      MEASURE: begin
        // Priority: clean tick beats a seed match arriving on the same cycle.
        if (i_max_tick) begin
          w_period = r_cnt;
          w_pass   = (r_cnt == PERIOD_CNT);
          w_err    = ERR_NONE;
          w_state  = DONE;
        end else if (i_lfsr_in == r_prev) begin
          w_err    = ERR_STUCK;
          w_period = r_cnt;
          w_state  = DONE;
        end else if (i_lfsr_in == r_seed) begin
          w_err    = ERR_REPEAT;
          w_period = r_cnt;
          w_state  = DONE;
        end else if (r_cnt == CNT_MAX) begin
          w_err    = ERR_TIMEOUT;
          w_period = CNT_MAX;
          w_state  = DONE;
        end else begin
          w_cnt  = r_cnt + CNT_W'(1);
          w_prev = i_lfsr_in;
        end
      end

      DONE: begin
        w_state = IDLE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    w_busy = (w_state == ARM) || (w_state == MEASURE);
    w_done = (w_state == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_seed   <= '0;
      r_prev   <= '0;
      r_pass   <= 1'b0;
      r_err    <= ERR_NONE;
      r_period <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_seed   <= w_seed;
      r_prev   <= w_prev;
      r_pass   <= w_pass;
      r_err    <= w_err;
      r_period <= w_period;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_pass   = r_pass;
  assign o_err    = r_err;
  assign o_period = r_period;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Randomized bench for lfsr_period_checker. Each scenario builds a per-cycle stimulus trace
// (start, max_tick, data), a reference model derives the expected result from the trace
// using the measurement rules directly, and the trace is then played into the DUT.
module tb_lfsr_period_checker;
  import lfsr_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             max_tick;
  logic [WIDTH-1:0] lfsr_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [1:0]       err;
  logic [CNT_W-1:0] period;

  int compared   = 0;
  int mismatched = 0;

  lfsr_period_checker u_dut (
    .i_clk      (clk),
    .i_reset    (reset_n),
    .i_start    (start),
    .i_max_tick (max_tick),
    .i_lfsr_in  (lfsr_in),
    .o_busy     (busy),
    .o_done     (done),
    .o_pass     (pass),
    .o_err      (err),
    .o_period   (period)
  );

  always #5 clk = ~clk;

  // Stimulus trace: index i is what the DUT sees on the i-th rising edge of a run.
  bit               g_start[$];
  bit               g_tick[$];
  logic [WIDTH-1:0] g_data[$];

  // Observations from the last run.
  int               obs_done_idx;
  int               obs_done_cnt;
  int               obs_busy_cnt;
  logic             obs_pass;
  logic [1:0]       obs_err;
  logic [CNT_W-1:0] obs_period;
  logic             snap_pass;
  logic [1:0]       snap_err;
  logic [CNT_W-1:0] snap_period;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    // x^12 + x^6 + x^4 + x + 1, maximal length
    return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
  endfunction

  task automatic clear_trace();
    g_start.delete();
    g_tick.delete();
    g_data.delete();
  endtask

  task automatic push(input bit s, input bit t, input logic [WIDTH-1:0] d);
    g_start.push_back(s);
    g_tick.push_back(t);
    g_data.push_back(d);
  endtask

  // Reference: index 0 is the start edge. ARM waits for a tick and gives up after 8191
  // edges. In MEASURE the length is edges since the arming tick; a tick ends cleanly,
  // a repeat of the previous cycle's value is stuck, a return to the arming value is an
  // early repeat, and reaching 8191 is a timeout.
  task automatic ref_model(output int e_done, output logic e_pass, output logic [1:0] e_err,
                           output int e_period);
    int a;
    a = -1;
    e_done = -1; e_pass = 1'b0; e_err = 2'b00; e_period = 0;
    for (int k = 1; k < g_tick.size(); k++) begin
      if (g_tick[k]) begin a = k; break; end
      if (k == 8191) begin e_done = k; e_err = 2'b11; e_period = 8191; return; end
    end
    if (a < 0) return;
    for (int j = a + 1; j < g_tick.size(); j++) begin
      int len;
      len = j - a;
      if (g_tick[j]) begin
        e_done = j; e_period = len; e_pass = (len == 4095); e_err = 2'b00; return;
      end
      if (g_data[j] == g_data[j-1]) begin e_done = j; e_period = len; e_err = 2'b01; return; end
      if (g_data[j] == g_data[a]) begin e_done = j; e_period = len; e_err = 2'b10; return; end
      if (len == 8191) begin e_done = j; e_period = 8191; e_err = 2'b11; return; end
    end
  endtask

  task automatic run_trace(input int n);
    obs_done_idx = -1; obs_done_cnt = 0; obs_busy_cnt = 0;
    obs_pass = 1'bx; obs_err = 2'bxx; obs_period = 'x;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start    = (i < g_start.size()) ? g_start[i] : 1'b0;
      max_tick = (i < g_tick.size()) ? g_tick[i] : 1'b0;
      lfsr_in  = (i < g_data.size()) ? g_data[i] : '0;
      @(posedge clk);
      #1;
      if (i == 0) begin snap_pass = pass; snap_err = err; snap_period = period; end
      if (busy) obs_busy_cnt++;
      if (done) begin
        obs_done_cnt++;
        if (obs_done_idx < 0) begin
          obs_done_idx = i; obs_pass = pass; obs_err = err; obs_period = period;
        end
      end
    end
    @(negedge clk);
    start = 1'b0; max_tick = 1'b0;
  endtask

  task automatic build_lfsr_trace();
    logic [WIDTH-1:0] s;
    s = WIDTH'($urandom_range(1, 4095));
    clear_trace();
    for (int i = 0; i < 8300; i++) begin
      push(i == 0, s == 12'h001, s);
      s = lfsr_step(s);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; max_tick = 1'b1; lfsr_in = '1;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
    compared++; if (pass !== 1'b0) begin mismatched++; $display("FAIL reset_pass got %b want 0", pass); end
    compared++; if (err !== 2'b00) begin mismatched++; $display("FAIL reset_err got %b want 00", err); end
    compared++; if (period !== '0) begin mismatched++; $display("FAIL reset_period got %0d want 0", period); end
    @(negedge clk);
    start = 1'b0; max_tick = 1'b0; lfsr_in = '0; reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_lfsr();
    int e_done, e_period; logic e_pass; logic [1:0] e_err;
    build_lfsr_trace();
    ref_model(e_done, e_pass, e_err, e_period);
    run_trace(e_done + 3);
    compared++; if (obs_done_idx !== e_done) begin mismatched++; $display("FAIL lfsr_done_cycle got %0d want %0d", obs_done_idx, e_done); end
    compared++; if (obs_done_cnt !== 1) begin mismatched++; $display("FAIL lfsr_done_pulses got %0d want 1", obs_done_cnt); end
    compared++; if (obs_busy_cnt !== e_done) begin mismatched++; $display("FAIL lfsr_busy_cycles got %0d want %0d", obs_busy_cnt, e_done); end
    compared++; if (obs_period !== CNT_W'(4095)) begin mismatched++; $display("FAIL lfsr_period got %0d want 4095", obs_period); end
    compared++; if (obs_pass !== 1'b1) begin mismatched++; $display("FAIL lfsr_pass got %b want 1", obs_pass); end
    compared++; if (obs_err !== e_err) begin mismatched++; $display("FAIL lfsr_err got %b want %b", obs_err, e_err); end
  endtask

  task automatic test_stub_counter();
    int e_done, e_period, ph; logic e_pass; logic [1:0] e_err; logic [WIDTH-1:0] base;
    ph = $urandom_range(1, 100); base = WIDTH'($urandom);
    clear_trace();
    for (int i = 0; i < 320; i++) push(i == 0, (i >= ph) && ((i - ph) % 100 == 0), base + WIDTH'(i));
    ref_model(e_done, e_pass, e_err, e_period);
    run_trace(e_done + 3);
    compared++; if (obs_done_idx !== e_done) begin mismatched++; $display("FAIL stub_done_cycle got %0d want %0d", obs_done_idx, e_done); end
    compared++; if (obs_period !== CNT_W'(e_period)) begin mismatched++; $display("FAIL stub_period got %0d want %0d", obs_period, e_period); end
    compared++; if (obs_pass !== e_pass) begin mismatched++; $display("FAIL stub_pass got %b want %b", obs_pass, e_pass); end
    compared++; if (obs_err !== e_err) begin mismatched++; $display("FAIL stub_err got %b want %b", obs_err, e_err); end
    // Results must stay put while idle, even with ticks arriving.
    max_tick = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    compared++; if (period !== CNT_W'(100)) begin mismatched++; $display("FAIL stub_hold_period got %0d want 100", period); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL stub_hold_done got %b want 0", done); end
    @(negedge clk);
    max_tick = 1'b0;
  endtask

  task automatic test_stuck();
    int e_done, e_period, a; logic e_pass; logic [1:0] e_err;
    a = $urandom_range(1, 30);
    clear_trace();
    for (int i = 0; i < a + 10; i++) push(i == 0, i == a, (i < a) ? WIDTH'($urandom) : '0);
    ref_model(e_done, e_pass, e_err, e_period);
    run_trace(e_done + 3);
    compared++; if (obs_done_idx !== a + 1) begin mismatched++; $display("FAIL stuck_done_cycle got %0d want %0d", obs_done_idx, a + 1); end
    compared++; if (obs_err !== ERR_STUCK) begin mismatched++; $display("FAIL stuck_err got %b want 01", obs_err); end
    compared++; if (obs_period !== CNT_W'(e_period)) begin mismatched++; $display("FAIL stuck_period got %0d want %0d", obs_period, e_period); end
    compared++; if (obs_pass !== 1'b0) begin mismatched++; $display("FAIL stuck_pass got %b want 0", obs_pass); end
  endtask

  task automatic test_repeat();
    int e_done, e_period, a, base; logic e_pass; logic [1:0] e_err;
    a = $urandom_range(1, 20); base = $urandom_range(0, 49);
    clear_trace();
    for (int i = 0; i < a + 60; i++) push(i == 0, i == a, WIDTH'((base + i) % 50));
    ref_model(e_done, e_pass, e_err, e_period);
    run_trace(e_done + 3);
    compared++; if (obs_err !== e_err) begin mismatched++; $display("FAIL repeat_err got %b want %b", obs_err, e_err); end
    compared++; if (obs_period !== CNT_W'(50)) begin mismatched++; $display("FAIL repeat_period got %0d want 50", obs_period); end
    compared++; if (obs_done_idx !== e_done) begin mismatched++; $display("FAIL repeat_done_cycle got %0d want %0d", obs_done_idx, e_done); end
  endtask

  task automatic test_timeout();
    int e_done, e_period; logic e_pass; logic [1:0] e_err;
    clear_trace();
    for (int i = 0; i < 8195; i++) push(i == 0, 1'b0, WIDTH'($urandom));
    ref_model(e_done, e_pass, e_err, e_period);
    // Start pulses while busy and on the DONE cycle must all be ignored.
    for (int k = 0; k < 8; k++) g_start[$urandom_range(1, 8190)] = 1'b1;
    g_start[e_done + 1] = 1'b1;
    run_trace(e_done + 4);
    compared++; if (obs_done_idx !== 8191) begin mismatched++; $display("FAIL timeout_done_cycle got %0d want 8191", obs_done_idx); end
    compared++; if (obs_err !== e_err) begin mismatched++; $display("FAIL timeout_err got %b want %b", obs_err, e_err); end
    compared++; if (obs_period !== CNT_W'(8191)) begin mismatched++; $display("FAIL timeout_period got %0d want 8191", obs_period); end
    compared++; if (obs_busy_cnt !== 8191) begin mismatched++; $display("FAIL timeout_busy_cycles got %0d want 8191", obs_busy_cnt); end
    compared++; if (obs_done_cnt !== 1) begin mismatched++; $display("FAIL timeout_done_pulses got %0d want 1", obs_done_cnt); end
  endtask

  task automatic test_back_to_back();
    int e_done, e_period, ph, p2; logic e_pass; logic [1:0] e_err;
    ph = $urandom_range(1, 50);
    clear_trace();
    for (int i = 0; i < ph + 4100; i++) push(i == 0, (i == ph) || (i == ph + 4095), WIDTH'(i));
    ref_model(e_done, e_pass, e_err, e_period);
    run_trace(e_done + 2);
    compared++; if (obs_pass !== 1'b1) begin mismatched++; $display("FAIL b2b_first_pass got %b want 1", obs_pass); end
    p2 = $urandom_range(20, 200); ph = $urandom_range(1, 50);
    clear_trace();
    for (int i = 0; i < ph + p2 + 5; i++) push(i == 0, (i == ph) || (i == ph + p2), WIDTH'(i + 7));
    ref_model(e_done, e_pass, e_err, e_period);
    run_trace(e_done + 3);
    compared++; if (snap_pass !== 1'b0 || snap_err !== 2'b00 || snap_period !== '0) begin
      mismatched++; $display("FAIL b2b_clear_on_start got pass=%b err=%b period=%0d want 0/00/0", snap_pass, snap_err, snap_period);
    end
    compared++; if (obs_period !== CNT_W'(p2)) begin mismatched++; $display("FAIL b2b_second_period got %0d want %0d", obs_period, p2); end
    compared++; if (obs_pass !== e_pass) begin mismatched++; $display("FAIL b2b_second_pass got %b want %b", obs_pass, e_pass); end
  endtask

  task automatic test_reset_mid();
    int e_done, e_period, a; logic e_pass; logic [1:0] e_err;
    build_lfsr_trace();
    a = -1;
    for (int k = 1; k < g_tick.size() && a < 0; k++) if (g_tick[k]) a = k;
    run_trace(a + 2000);
    @(posedge clk);
    reset_n = 1'b0;
    lfsr_in = g_data[a + 2000];
    @(posedge clk);
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy got %b want 0", busy); end
    compared++; if (done !== 1'b0 || obs_done_cnt !== 0) begin mismatched++; $display("FAIL midreset_done got %b/%0d want 0/0", done, obs_done_cnt); end
    compared++; if (pass !== 1'b0 || err !== 2'b00 || period !== '0) begin
      mismatched++; $display("FAIL midreset_results got pass=%b err=%b period=%0d want 0/00/0", pass, err, period);
    end
    @(negedge clk);
    reset_n = 1'b1;
    build_lfsr_trace();
    ref_model(e_done, e_pass, e_err, e_period);
    run_trace(e_done + 3);
    compared++; if (obs_period !== CNT_W'(4095)) begin mismatched++; $display("FAIL midreset_rerun_period got %0d want 4095", obs_period); end
    compared++; if (obs_pass !== 1'b1) begin mismatched++; $display("FAIL midreset_rerun_pass got %b want 1", obs_pass); end
    compared++; if (obs_done_idx !== e_done) begin mismatched++; $display("FAIL midreset_rerun_done_cycle got %0d want %0d", obs_done_idx, e_done); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; max_tick = 1'b0; lfsr_in = '0;
    test_reset();
    test_lfsr();
    test_stub_counter();
    test_stuck();
    test_repeat();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute bound so a wedged run still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got no completion want completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1);
  end

endmodule
